// File: rtl/main_memory_subsystem.sv
// Backing store for the RV32IM core. It holds a read-only instruction array and
// a read/write data array, both built from 128-bit blocks. Each array sits
// behind its own fixed-latency busywait port.
module main_memory_subsystem #(
  parameter int    INST_BLOCKS    = 16,
  parameter int    DATA_BLOCKS    = 64,
  parameter int    LATENCY        = 5,
  parameter string INST_INIT_FILE = ""
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         INST_MEM_READ,
  input  logic [27:0]  INST_MEM_ADDRESS,
  output logic [127:0] INST_MEM_READDATA,
  output logic         INST_MEM_BUSYWAIT,
  input  logic         DATA_MEM_READ,
  input  logic         DATA_MEM_WRITE,
  input  logic [27:0]  DATA_MEM_ADDRESS,
  input  logic [127:0] DATA_MEM_WRITEDATA,
  output logic [127:0] DATA_MEM_READDATA,
  output logic         DATA_MEM_BUSYWAIT
);
  localparam int IAW = $clog2(INST_BLOCKS);
  localparam int DAW = $clog2(DATA_BLOCKS);
  localparam int CW  = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Upper address bits alias onto the array, so they are deliberately dropped
  logic unused_addr_bits;
  assign unused_addr_bits = ^{INST_MEM_ADDRESS[27:IAW], DATA_MEM_ADDRESS[27:DAW]};

  // ---------------- instruction port ----------------
  logic [127:0]   inst_mem [INST_BLOCKS];
  state_e         i_state_q, i_state_d;
  logic [CW-1:0]  i_cnt_q;
  logic [IAW-1:0] i_addr_q;
  logic [127:0]   i_rdata_q;

  // Instruction FSM state register
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) i_state_q <= IDLE;
    else        i_state_q <= i_state_d;

  // Instruction FSM next state
  always_comb begin
    i_state_d = i_state_q;
    case (i_state_q)
      IDLE:    if (INST_MEM_READ) i_state_d = BUSY;
      BUSY:    if (i_cnt_q == '0) i_state_d = DONE;
      DONE:    i_state_d = IDLE;
      default: i_state_d = IDLE;
    endcase
  end

  // Busywait is combinational so the cache stalls in the request cycle
  always_comb INST_MEM_BUSYWAIT = (i_state_q == IDLE && INST_MEM_READ) || (i_state_q == BUSY);

  // Instruction datapath: latch on accept, count down, deliver the block on completion
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      i_cnt_q   <= '0;
      i_addr_q  <= '0;
      i_rdata_q <= '0;
    end else if (i_state_q == IDLE && INST_MEM_READ) begin
      i_cnt_q  <= CNT_INIT;
      i_addr_q <= INST_MEM_ADDRESS[IAW-1:0];
    end else if (i_state_q == BUSY) begin
      if (i_cnt_q != '0) i_cnt_q   <= i_cnt_q - CW'(1);
      else               i_rdata_q <= inst_mem[i_addr_q];
    end

  assign INST_MEM_READDATA = i_rdata_q;

  // ---------------- data port ----------------
  logic [127:0]   data_mem_q [DATA_BLOCKS];
  state_e         d_state_q, d_state_d;
  logic [CW-1:0]  d_cnt_q;
  logic [DAW-1:0] d_addr_q;
  logic [127:0]   d_wdata_q;
  logic           d_wr_q;
  logic           d_req;
  logic           d_last;

  assign d_req  = DATA_MEM_READ | DATA_MEM_WRITE;
  assign d_last = (d_state_q == BUSY) && (d_cnt_q == '0);

  // Data FSM state register
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) d_state_q <= IDLE;
    else        d_state_q <= d_state_d;

  // Data FSM next state
  always_comb begin
    d_state_d = d_state_q;
    case (d_state_q)
      IDLE:    if (d_req) d_state_d = BUSY;
      BUSY:    if (d_cnt_q == '0) d_state_d = DONE;
      DONE:    d_state_d = IDLE;
      default: d_state_d = IDLE;
    endcase
  end

  // Data busywait, combinational on the request while idle
  always_comb DATA_MEM_BUSYWAIT = (d_state_q == IDLE && d_req) || (d_state_q == BUSY);

  // Data datapath; write wins when read and write are both raised
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      d_cnt_q   <= '0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_wr_q    <= 1'b0;
      DATA_MEM_READDATA <= '0;
    end else if (d_state_q == IDLE && d_req) begin
      d_cnt_q   <= CNT_INIT;
      d_addr_q  <= DATA_MEM_ADDRESS[DAW-1:0];
      d_wdata_q <= DATA_MEM_WRITEDATA;
      d_wr_q    <= DATA_MEM_WRITE;
    end else if (d_state_q == BUSY) begin
      if (d_cnt_q != '0) d_cnt_q <= d_cnt_q - CW'(1);
      else if (!d_wr_q)  DATA_MEM_READDATA <= data_mem_q[d_addr_q];
    end

  // Data array: cleared by reset; a write lands on the BUSY-to-DONE edge
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      for (int k = 0; k < DATA_BLOCKS; k++) data_mem_q[k] <= '0;
    end else if (d_last && d_wr_q) begin
      data_mem_q[d_addr_q] <= d_wdata_q;
    end

endmodule

// File: tb/tb_main_memory_subsystem.sv
// Bench for main_memory_subsystem. A transaction-level model keyed on the
// absolute cycle at which each access completes sits beside directed and
// random traffic.
module tb_main_memory_subsystem;
  localparam int LAT = 5;
  localparam int IB  = 16;
  localparam int DB  = 64;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         INST_MEM_READ = 1'b0;
  logic [27:0]  INST_MEM_ADDRESS = '0;
  logic [127:0] INST_MEM_READDATA;
  logic         INST_MEM_BUSYWAIT;
  logic         DATA_MEM_READ = 1'b0;
  logic         DATA_MEM_WRITE = 1'b0;
  logic [27:0]  DATA_MEM_ADDRESS = '0;
  logic [127:0] DATA_MEM_WRITEDATA = '0;
  logic [127:0] DATA_MEM_READDATA;
  logic         DATA_MEM_BUSYWAIT;

  main_memory_subsystem #(.INST_BLOCKS(IB), .DATA_BLOCKS(DB), .LATENCY(LAT), .INST_INIT_FILE("")) dut (
    .CLK(CLK), .RESET(RESET),
    .INST_MEM_READ(INST_MEM_READ), .INST_MEM_ADDRESS(INST_MEM_ADDRESS),
    .INST_MEM_READDATA(INST_MEM_READDATA), .INST_MEM_BUSYWAIT(INST_MEM_BUSYWAIT),
    .DATA_MEM_READ(DATA_MEM_READ), .DATA_MEM_WRITE(DATA_MEM_WRITE),
    .DATA_MEM_ADDRESS(DATA_MEM_ADDRESS), .DATA_MEM_WRITEDATA(DATA_MEM_WRITEDATA),
    .DATA_MEM_READDATA(DATA_MEM_READDATA), .DATA_MEM_BUSYWAIT(DATA_MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [127:0] inst_m [IB];
  logic [127:0] data_m [DB];
  int           cyc = 0;
  int           i_end = -1, d_end = -1;   // cycle of DONE for the access in flight
  int           i_idx, d_idx;
  bit           d_is_wr;
  logic [127:0] d_wd;
  logic [127:0] i_exp = '0, d_exp = '0;

  initial for (int k = 0; k < DB; k++) data_m[k] = '0;

  // Compare every cycle, mid-way between the stimulus edge and the clock edge
  always @(negedge CLK) begin
    #2;
    if (!RESET) begin
      for (int k = 0; k < DB; k++) data_m[k] = '0;
      i_exp = '0; d_exp = '0; i_end = -1; d_end = -1;
      chk("rst_ibusy", 128'(INST_MEM_BUSYWAIT), 128'(INST_MEM_READ));
      chk("rst_dbusy", 128'(DATA_MEM_BUSYWAIT), 128'(DATA_MEM_READ | DATA_MEM_WRITE));
      chk("rst_irdata", INST_MEM_READDATA, '0);
      chk("rst_drdata", DATA_MEM_READDATA, '0);
    end else begin
      // instruction port
      if (i_end == cyc) i_exp = inst_m[i_idx];
      chk("m_ibusy", 128'(INST_MEM_BUSYWAIT),
          128'((i_end > cyc) ? 1'b1 : (i_end == cyc) ? 1'b0 : INST_MEM_READ));
      chk("m_irdata", INST_MEM_READDATA, i_exp);
      if (i_end == cyc) i_end = -1;
      else if (i_end < 0 && INST_MEM_READ) begin
        i_end = cyc + LAT + 1;
        i_idx = int'(INST_MEM_ADDRESS) % IB;
      end
      // data port
      if (d_end == cyc) begin
        if (d_is_wr) data_m[d_idx] = d_wd;
        else         d_exp = data_m[d_idx];
      end
      chk("m_dbusy", 128'(DATA_MEM_BUSYWAIT),
          128'((d_end > cyc) ? 1'b1 : (d_end == cyc) ? 1'b0 : (DATA_MEM_READ | DATA_MEM_WRITE)));
      chk("m_drdata", DATA_MEM_READDATA, d_exp);
      if (d_end == cyc) d_end = -1;
      else if (d_end < 0 && (DATA_MEM_READ || DATA_MEM_WRITE)) begin
        d_end   = cyc + LAT + 1;
        d_idx   = int'(DATA_MEM_ADDRESS) % DB;
        d_is_wr = DATA_MEM_WRITE;
        d_wd    = DATA_MEM_WRITEDATA;
      end
    end
    cyc++;
  end

  // ---------------- directed helpers ----------------
  // Count busy cycles from the request cycle; returns at sample point of DONE
  task automatic wait_port(input bit inst, output int n);
    n = 0;
    #2;
    while ((inst ? INST_MEM_BUSYWAIT : DATA_MEM_BUSYWAIT) && n < 20) begin
      n++;
      @(negedge CLK); #2;
    end
  endtask

  task automatic data_op(input bit rd, input bit wr, input int addr, input logic [127:0] wd,
                         output logic [127:0] rdata, output int n);
    @(negedge CLK);
    DATA_MEM_READ = rd; DATA_MEM_WRITE = wr;
    DATA_MEM_ADDRESS = 28'(addr); DATA_MEM_WRITEDATA = wd;
    wait_port(1'b0, n);
    rdata = DATA_MEM_READDATA;
    @(negedge CLK);
    DATA_MEM_READ = 1'b0; DATA_MEM_WRITE = 1'b0;
  endtask

  logic [127:0] rd, v;
  int           n, ni, nd;
  localparam logic [127:0] IBLK2 = 128'h00000013_00500093_00A00113_002081B3;
  localparam logic [127:0] DPAT  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  initial begin
    // Backdoor ROM image, mirrored in the model
    for (int k = 0; k < IB; k++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      if (k == 2) v = IBLK2;
      inst_m[k] = v;
      dut.inst_mem[k] = v;
    end
    #1 RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    #2;
    chk("idle_irdata", INST_MEM_READDATA, '0);
    chk("idle_drdata", DATA_MEM_READDATA, '0);
    chk("idle_ibusy", 128'(INST_MEM_BUSYWAIT), '0);
    chk("idle_dbusy", 128'(DATA_MEM_BUSYWAIT), '0);
    data_op(1, 0, 3, '0, rd, n);
    chk("blk3_zero", rd, '0);

    // Instruction fetch of block 2
    @(negedge CLK);
    INST_MEM_READ = 1'b1; INST_MEM_ADDRESS = 28'd2;
    wait_port(1'b1, n);
    chk("ifetch_busy_cycles", 128'(n), 128'(6));
    chk("ifetch_data", INST_MEM_READDATA, IBLK2);
    @(negedge CLK); INST_MEM_READ = 1'b0;

    // Data write then read of block 5
    data_op(0, 1, 5, DPAT, rd, n);
    chk("wr5_busy_cycles", 128'(n), 128'(6));
    data_op(1, 0, 5, '0, rd, n);
    chk("rd5_busy_cycles", 128'(n), 128'(6));
    chk("rd5_data", rd, DPAT);
    data_op(1, 0, 6, '0, rd, n);
    chk("rd6_zero", rd, '0);

    // Aliasing: 69 maps onto block 5
    data_op(0, 1, 69, 128'h1111_2222_3333_4444_5555_6666_7777_8888, rd, n);
    data_op(1, 0, 5, '0, rd, n);
    chk("alias_69_5", rd, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    // Read+write together is a write
    data_op(1, 1, 7, 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F, rd, n);
    data_op(1, 0, 7, '0, rd, n);
    chk("rw_prio_wr", rd, 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F);

    // Concurrent instruction read and data write of block 1
    @(negedge CLK);
    INST_MEM_READ = 1'b1; INST_MEM_ADDRESS = 28'd1;
    DATA_MEM_WRITE = 1'b1; DATA_MEM_ADDRESS = 28'd1; DATA_MEM_WRITEDATA = 128'hC0FFEE;
    ni = 0; nd = 0;
    #2;
    for (int t = 0; t < 20 && (INST_MEM_BUSYWAIT || DATA_MEM_BUSYWAIT); t++) begin
      if (INST_MEM_BUSYWAIT) ni++;
      if (DATA_MEM_BUSYWAIT) nd++;
      @(negedge CLK); #2;
    end
    chk("conc_ibusy", 128'(ni), 128'(6));
    chk("conc_dbusy", 128'(nd), 128'(6));
    chk("conc_idata", INST_MEM_READDATA, inst_m[1]);
    @(negedge CLK); INST_MEM_READ = 1'b0; DATA_MEM_WRITE = 1'b0;
    data_op(1, 0, 1, '0, rd, n);
    chk("conc_dread", rd, 128'hC0FFEE);

    // Reset in BUSY cycle 3 of a write to block 9
    @(negedge CLK);
    DATA_MEM_WRITE = 1'b1; DATA_MEM_ADDRESS = 28'd9; DATA_MEM_WRITEDATA = '1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0; DATA_MEM_WRITE = 1'b0;
    #2 chk("abort_busy", 128'(DATA_MEM_BUSYWAIT), '0);
    @(negedge CLK); RESET = 1'b1;
    data_op(1, 0, 9, '0, rd, n);
    chk("abort_blk9", rd, '0);
    chk("abort_rd_cycles", 128'(n), 128'(6));

    // Random traffic, checked against the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      RESET              = ($urandom_range(399) != 0);
      INST_MEM_READ      = $urandom_range(1);
      INST_MEM_ADDRESS   = 28'($urandom);
      DATA_MEM_READ      = ($urandom_range(2) == 0);
      DATA_MEM_WRITE     = ($urandom_range(2) == 0);
      DATA_MEM_ADDRESS   = ($urandom_range(1) != 0) ? 28'($urandom_range(7)) : 28'($urandom);
      DATA_MEM_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge CLK);
    RESET = 1'b1; INST_MEM_READ = 1'b0; DATA_MEM_READ = 1'b0; DATA_MEM_WRITE = 1'b0;
    repeat (10) @(negedge CLK);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
